// File: rtl/spi_xfer_queue_pkg.sv
// spi_xfer_pkg: shared FSM state, SPI mode encodings and byte width for the SPI transfer queue.
package spi_xfer_pkg;
    localparam int BYTE_W = 8;
    localparam logic [1:0] MODE0 = 2'd0;
    localparam logic [1:0] MODE1 = 2'd1;
    localparam logic [1:0] MODE2 = 2'd2;
    localparam logic [1:0] MODE3 = 2'd3;
    typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;
endpackage

// File: rtl/spi_xfer_queue_fifo.sv
// spi_sync_fifo: circular synchronous FIFO with an extra pointer bit so full and empty differ.
module spi_sync_fifo
    import spi_xfer_pkg::*;
#(
    parameter int W = BYTE_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    assign level = wp - rp;
    assign rdata = mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/spi_xfer_queue.sv
// spi_xfer_queue: TX/RX byte queues feeding an SPI master engine with burst chip-select control.
// Optional WAIT watchdog enabled by defining SPI_XFER_TIMEOUT_EN.
module spi_xfer_queue
    import spi_xfer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CS_GAP = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [1:0]              cfg_mode,
    input  logic [4:0]              cfg_clk_div,
    input  logic [BYTE_W-1:0]       tx_wdata,
    input  logic                    tx_wvalid,
    output logic                    tx_wready,
    output logic [BYTE_W-1:0]       rx_rdata,
    output logic                    rx_rvalid,
    input  logic                    rx_rready,
    output logic                    eng_start,
    output logic [BYTE_W-1:0]       eng_mosi_data,
    output logic [1:0]              eng_mode,
    output logic [4:0]              eng_clk_div,
    input  logic                    eng_done,
    input  logic [BYTE_W-1:0]       eng_miso_data,
    output logic                    ss_n,
    output logic [$clog2(DEPTH):0]  tx_level,
    output logic [$clog2(DEPTH):0]  rx_level,
    output logic                    err_timeout
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int GW = $clog2(CS_GAP) + 1;
    state_t state;
    logic inflight, slot_free, launch, tx_pop, rx_push, timed_out;
    logic [BYTE_W-1:0] tx_rdata;
    logic [GW-1:0] gap;
    assign tx_wready = tx_level != LW'(DEPTH);
    assign rx_rvalid = rx_level != '0;
    // Reserve an RX slot for the byte in flight so a returned byte always has room.
    assign slot_free = (rx_level + LW'(inflight)) < LW'(DEPTH);
    assign launch = enable && tx_level != '0 && slot_free;
    assign tx_pop = launch && (state == IDLE || (state == WAIT && eng_done));
    assign rx_push = state == WAIT && eng_done;
    spi_sync_fifo #(.W(BYTE_W), .DEPTH(DEPTH)) u_tx (
        .clk(clk), .reset(reset), .push(tx_wvalid && tx_wready), .wdata(tx_wdata),
        .pop(tx_pop), .rdata(tx_rdata), .level(tx_level)
    );
    spi_sync_fifo #(.W(BYTE_W), .DEPTH(DEPTH)) u_rx (
        .clk(clk), .reset(reset), .push(rx_push), .wdata(eng_miso_data),
        .pop(rx_rvalid && rx_rready), .rdata(rx_rdata), .level(rx_level)
    );
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            ss_n <= 1'b1;
            eng_start <= 1'b0;
            eng_mosi_data <= '0;
            eng_mode <= MODE0;
            eng_clk_div <= '0;
            inflight <= 1'b0;
            gap <= '0;
        end else begin
            eng_start <= tx_pop;
            if (tx_pop) begin
                eng_mosi_data <= tx_rdata;
                eng_mode <= cfg_mode;
                eng_clk_div <= cfg_clk_div;
                ss_n <= 1'b0;
                inflight <= 1'b1;
                state <= START;
            end else begin
                case (state)
                    START: state <= WAIT;
                    WAIT: if (eng_done || timed_out) begin
                        state <= HOLD;
                        gap <= GW'(CS_GAP - 1);
                        inflight <= 1'b0;
                    end
                    HOLD: if (gap == '0) begin
                        ss_n <= 1'b1;
                        state <= IDLE;
                    end else begin
                        gap <= gap - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
`ifdef SPI_XFER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] wait_cnt;
    assign timed_out = state == WAIT && !eng_done && wait_cnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
            err_timeout <= 1'b0;
        end else begin
            wait_cnt <= state == WAIT ? wait_cnt + 1'b1 : '0;
            if (timed_out) err_timeout <= 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
    assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_spi_xfer_queue.sv
// tb_spi_xfer_queue: directed bench with an engine model and RX/MOSI scoreboards for spi_xfer_queue.
module tb_spi_xfer_queue;
    import spi_xfer_pkg::*;
    localparam int DEPTH = 8;
    localparam int CS_GAP = 2;
    localparam int TO = 16;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic [1:0] cfg_mode = 2'd0;
    logic [4:0] cfg_clk_div = 5'd0;
    logic [7:0] tx_wdata = 8'd0;
    logic tx_wvalid = 1'b0;
    logic tx_wready;
    logic [7:0] rx_rdata;
    logic rx_rvalid;
    logic rx_rready = 1'b0;
    logic eng_start;
    logic [7:0] eng_mosi_data;
    logic [1:0] eng_mode;
    logic [4:0] eng_clk_div;
    logic eng_done;
    logic [7:0] eng_miso_data;
    logic ss_n;
    logic [3:0] tx_level, rx_level;
    logic err_timeout;
    int tests = 0;
    int fails = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_mosi[$];
    always #5 clk = ~clk;
    spi_xfer_queue #(.DEPTH(DEPTH), .CS_GAP(CS_GAP), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .enable(enable), .cfg_mode(cfg_mode), .cfg_clk_div(cfg_clk_div),
        .tx_wdata(tx_wdata), .tx_wvalid(tx_wvalid), .tx_wready(tx_wready),
        .rx_rdata(rx_rdata), .rx_rvalid(rx_rvalid), .rx_rready(rx_rready),
        .eng_start(eng_start), .eng_mosi_data(eng_mosi_data), .eng_mode(eng_mode),
        .eng_clk_div(eng_clk_div), .eng_done(eng_done), .eng_miso_data(eng_miso_data),
        .ss_n(ss_n), .tx_level(tx_level), .rx_level(rx_level), .err_timeout(err_timeout)
    );
    // Engine model: answers each start three cycles later with mosi ^ 8'h99.
    logic auto_eng = 1'b1;
    logic man_done = 1'b0;
    logic [7:0] man_miso = 8'd0;
    logic [2:0] ecnt = 3'd0;
    always @(posedge clk) ecnt <= (eng_start && auto_eng) ? 3'd3 : (ecnt != 0 ? ecnt - 3'd1 : 3'd0);
    assign eng_done = (auto_eng && ecnt == 3'd1) || man_done;
    assign eng_miso_data = man_done ? man_miso : eng_mosi_data ^ 8'h99;
    int starts = 0;
    int rels = 0;
    int chk_idx = 0;
    logic ss_prev = 1'b1;
    logic [7:0] mosi_log [256];
    always @(negedge clk) begin
        if (eng_start) begin
            mosi_log[starts[7:0]] = eng_mosi_data;
            starts = starts + 1;
        end
        if (!ss_prev && ss_n) rels = rels + 1;
        ss_prev = ss_n;
    end
    initial begin
        #400000;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1, "watchdog");
    end
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic push(input logic [7:0] b);
        tx_wdata = b;
        tx_wvalid = 1'b1;
        exp_mosi.push_back(b);
        exp_rx.push_back(b ^ 8'h99);
        tick(1);
        tx_wvalid = 1'b0;
    endtask
    task automatic pop_rx(input string tag);
        int k = 0;
        while (!rx_rvalid && k < 50) begin tick(1); k++; end
        if (exp_rx.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        else chk(tag, {24'd0, rx_rdata}, {24'd0, exp_rx.pop_front()});
        rx_rready = 1'b1;
        tick(1);
        rx_rready = 1'b0;
    endtask
    task automatic check_starts();
        while (chk_idx < starts) begin
            if (exp_mosi.size() == 0) chk("mosi_sb_empty", 32'd1, 32'd0);
            else chk("mosi", {24'd0, mosi_log[chk_idx[7:0]]}, {24'd0, exp_mosi.pop_front()});
            chk_idx++;
        end
    endtask
    task automatic wait_rx_level(input logic [3:0] n, input int budget, input string tag);
        int k = 0;
        while (rx_level != n && k < budget) begin tick(1); k++; end
        chk(tag, {28'd0, rx_level}, {28'd0, n});
    endtask
    task automatic wait_ss_high(input int budget, input string tag);
        int k = 0;
        while (!ss_n && k < budget) begin tick(1); k++; end
        chk(tag, {31'd0, ss_n}, 32'd1);
    endtask
    initial begin
        int s0, r0;
        tick(3);
        chk("rst_tx_level", {28'd0, tx_level}, 32'd0);
        chk("rst_rx_level", {28'd0, rx_level}, 32'd0);
        chk("rst_ss_n", {31'd0, ss_n}, 32'd1);
        chk("rst_eng_start", {31'd0, eng_start}, 32'd0);
        chk("rst_mosi", {24'd0, eng_mosi_data}, 32'd0);
        chk("rst_mode", {30'd0, eng_mode}, 32'd0);
        chk("rst_div", {27'd0, eng_clk_div}, 32'd0);
        chk("rst_err", {31'd0, err_timeout}, 32'd0);
        chk("rst_wready", {31'd0, tx_wready}, 32'd1);
        chk("rst_rvalid", {31'd0, rx_rvalid}, 32'd0);
        reset = 1'b1;
        enable = 1'b1;
        cfg_clk_div = 5'd3;
        tick(1);
        // Single byte: latency, latched data, ss_n release after CS_GAP.
        push(8'hA5);
        chk("lat_start_early", {31'd0, eng_start}, 32'd0);
        tick(1);
        chk("lat_start", {31'd0, eng_start}, 32'd1);
        chk("lat_mosi", {24'd0, eng_mosi_data}, 32'hA5);
        chk("lat_ss_n", {31'd0, ss_n}, 32'd0);
        chk("lat_div", {27'd0, eng_clk_div}, 32'd3);
        tick(1);
        chk("start_one_cycle", {31'd0, eng_start}, 32'd0);
        wait_rx_level(4'd1, 20, "single_rx_level");
        chk("single_miso", {24'd0, rx_rdata}, 32'h3C);
        tick(CS_GAP - 1);
        chk("gap_ss_low", {31'd0, ss_n}, 32'd0);
        tick(1);
        chk("gap_ss_high", {31'd0, ss_n}, 32'd1);
        pop_rx("single_pop");
        check_starts();
        // Burst of three with one ss_n release.
        s0 = starts;
        r0 = rels;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        wait_rx_level(4'd3, 60, "burst_rx_level");
        wait_ss_high(20, "burst_ss_release");
        chk("burst_starts", starts - s0, 32'd3);
        chk("burst_releases", rels - r0, 32'd1);
        check_starts();
        repeat (3) pop_rx("burst_pop");
        // TX full, RX full stall, one pop frees exactly one transfer.
        enable = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        chk("tx_full_level", {28'd0, tx_level}, 32'd8);
        chk("tx_full_wready", {31'd0, tx_wready}, 32'd0);
        tx_wdata = 8'hFF;
        tx_wvalid = 1'b1;
        tick(1);
        tx_wvalid = 1'b0;
        chk("tx_overflow_ignored", {28'd0, tx_level}, 32'd8);
        enable = 1'b1;
        wait_rx_level(4'd8, 150, "rx_fill");
        push(8'h18);
        push(8'h19);
        s0 = starts;
        tick(30);
        chk("rx_full_stall", starts - s0, 32'd0);
        chk("rx_full_tx_level", {28'd0, tx_level}, 32'd2);
        pop_rx("fill_pop");
        tick(30);
        chk("one_more_start", starts - s0, 32'd1);
        chk("one_more_tx_level", {28'd0, tx_level}, 32'd1);
        chk("one_more_rx_level", {28'd0, rx_level}, 32'd8);
        while (exp_rx.size() > 0) pop_rx("drain_pop");
        wait_ss_high(30, "drain_ss_release");
        check_starts();
        // Reset during WAIT, then a stale done.
        auto_eng = 1'b0;
        push(8'h42);
        tick(3);
        chk("pre_reset_ss_low", {31'd0, ss_n}, 32'd0);
        check_starts();
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        exp_rx.delete();
        man_miso = 8'h77;
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        tick(2);
        chk("stale_rx_level", {28'd0, rx_level}, 32'd0);
        chk("stale_tx_level", {28'd0, tx_level}, 32'd0);
        chk("stale_ss_n", {31'd0, ss_n}, 32'd1);
        chk("stale_rvalid", {31'd0, rx_rvalid}, 32'd0);
        // Config change mid-WAIT applies only at the next transfer.
        push(8'h55);
        tick(2);
        cfg_mode = MODE3;
        tick(2);
        chk("mode_held", {30'd0, eng_mode}, 32'd0);
        push(8'h66);
        man_miso = 8'h55 ^ 8'h99;
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        chk("mode_next_start", {31'd0, eng_start}, 32'd1);
        chk("mode_next", {30'd0, eng_mode}, 32'd3);
        chk("mode_next_ss", {31'd0, ss_n}, 32'd0);
        tick(2);
        man_miso = 8'h66 ^ 8'h99;
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        wait_ss_high(20, "mode_ss_release");
        pop_rx("mode_pop");
        pop_rx("mode_pop");
        check_starts();
        cfg_mode = MODE0;
        auto_eng = 1'b1;
        // enable dropped mid-transfer: byte completes, then release.
        s0 = starts;
        push(8'hC3);
        push(8'hC4);
        enable = 1'b0;
        wait_rx_level(4'd1, 20, "en_off_rx");
        wait_ss_high(20, "en_off_release");
        tick(5);
        chk("en_off_starts", starts - s0, 32'd1);
        chk("en_off_tx_level", {28'd0, tx_level}, 32'd1);
        enable = 1'b1;
        wait_rx_level(4'd2, 30, "en_on_rx");
        pop_rx("en_pop");
        pop_rx("en_pop");
        wait_ss_high(20, "en_on_release");
        check_starts();
        // Engine never answers.
        auto_eng = 1'b0;
        push(8'h99);
        tick(1);
        chk("to_start", {31'd0, eng_start}, 32'd1);
`ifdef SPI_XFER_TIMEOUT_EN
        tick(TO);
        chk("to_err_early", {31'd0, err_timeout}, 32'd0);
        tick(1);
        chk("to_err", {31'd0, err_timeout}, 32'd1);
        chk("to_rx_level", {28'd0, rx_level}, 32'd0);
        tick(CS_GAP - 1);
        chk("to_ss_low", {31'd0, ss_n}, 32'd0);
        tick(1);
        chk("to_ss_high", {31'd0, ss_n}, 32'd1);
        tick(4);
        chk("to_sticky", {31'd0, err_timeout}, 32'd1);
        void'(exp_rx.pop_back());
`else
        tick(60);
        chk("nto_still_waiting", {31'd0, ss_n}, 32'd0);
        chk("nto_err", {31'd0, err_timeout}, 32'd0);
        chk("nto_rx_level", {28'd0, rx_level}, 32'd0);
        man_miso = 8'h99 ^ 8'h99;
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        pop_rx("nto_pop");
        wait_ss_high(20, "nto_release");
`endif
        check_starts();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
